// File: rtl/bp_update_ctrl_pkg.sv
// Shared widths, FIFO depth, FSM encoding and entry layout for the branch-predictor update path.
// The global_params values are defined here (guarded) so every file of this slice sees the same widths.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BP_SIZE
`define BP_SIZE 16
`endif
`ifndef BP_SIZE_WIDTH
`define BP_SIZE_WIDTH 4
`endif

package bp_update_ctrl_pkg;

  localparam int XLEN          = `XLEN;
  localparam int BP_SIZE       = `BP_SIZE;
  localparam int BP_SIZE_WIDTH = `BP_SIZE_WIDTH;
  localparam int FIFO_DEPTH    = 4;
  localparam int ENTRY_W       = BP_SIZE_WIDTH + 2;

  localparam logic [BP_SIZE_WIDTH-1:0] LAST_IDX = BP_SIZE_WIDTH'(BP_SIZE - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [BP_SIZE_WIDTH-1:0] index;
    logic                     jump;
    logic                     correct;
  } bp_entry_t;

  // Only the low address bits index the predictor table.
  function automatic bp_entry_t make_entry(input logic [XLEN-1:0] addr,
                                           input logic jump, input logic correct);
    bp_entry_t e;
    e.index   = addr[BP_SIZE_WIDTH-1:0];
    e.jump    = jump;
    e.correct = correct;
    return e;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// Four-entry update queue: two pushes (slot 0 before slot 1) and one pop per cycle.
module bp_update_fifo
  import bp_update_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push0,
  input  logic [ENTRY_W-1:0] i_data0,
  input  logic               i_push1,
  input  logic [ENTRY_W-1:0] i_data1,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [ENTRY_W-1:0] o_head,
  output logic [2:0]         o_count
);

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]         r_wrPtr;
  logic [1:0]         r_rdPtr;
  logic [2:0]         r_count;
  logic [1:0]         w_slot1Ptr;
  logic [2:0]         w_enqCnt;

  assign w_slot1Ptr = i_push0 ? r_wrPtr + 2'd1 : r_wrPtr;
  assign w_enqCnt   = {2'b00, i_push0} + {2'b00, i_push1};
  assign o_head     = r_mem[r_rdPtr];
  assign o_count    = r_count;

  always_ff @(posedge i_clk) begin
    if (i_push0) r_mem[r_wrPtr] <= i_data0;
    if (i_push1) r_mem[w_slot1Ptr] <= i_data1;
  end

  // A flush discards everything, including entries pushed in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else if (i_flush) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      r_wrPtr <= r_wrPtr + w_enqCnt[1:0];
      if (i_pop) r_rdPtr <= r_rdPtr + 2'd1;
      r_count <= r_count + w_enqCnt - {2'b00, i_pop};
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Serialises dual-slot ROB branch updates onto the single predictor write port and runs table clears.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rob_bp_enable0,
  input  logic [XLEN-1:0]          i_rob_bp_inst_addr0,
  input  logic                     i_rob_bp_jump0,
  input  logic                     i_rob_bp_correct0,
  input  logic                     i_rob_bp_enable1,
  input  logic [XLEN-1:0]          i_rob_bp_inst_addr1,
  input  logic                     i_rob_bp_jump1,
  input  logic                     i_rob_bp_correct1,
  input  logic                     i_clr_req,
  output logic                     o_bpu_full,
  output logic                     o_bp_wr_enable,
  output logic [BP_SIZE_WIDTH-1:0] o_bp_wr_index,
  output logic                     o_bp_wr_jump,
  output logic                     o_bp_wr_correct,
  output logic                     o_bp_wr_clear,
  output logic                     o_clr_done,
  output logic                     o_bpu_overflow,
  output logic [XLEN-1:0]          o_upd_cnt
);

  state_e                   r_state;
  logic [BP_SIZE_WIDTH-1:0] r_walkIdx;
  logic                     r_wrEnable;
  logic [BP_SIZE_WIDTH-1:0] r_wrIndex;
  logic                     r_wrJump;
  logic                     r_wrCorrect;
  logic                     r_wrClear;
  logic                     r_lastClear;
  logic                     r_clrDone;
  logic                     r_overflow;
  logic [XLEN-1:0]          r_updCnt;

  logic [2:0]         w_count;
  logic [ENTRY_W-1:0] w_headBits;
  bp_entry_t          w_head;
  logic               w_full;
  logic               w_push0;
  logic               w_push1;
  logic               w_pop;
  logic               w_flush;
  logic               w_unusedAddrBits;

  // Full at three entries so the ROB can always drop two updates in after seeing it low.
  assign w_full  = (w_count >= 3'd3) || (r_state == ST_CLEAR);
  assign w_push0 = i_rob_bp_enable0 && !w_full;
  assign w_push1 = i_rob_bp_enable1 && !w_full;
  assign w_flush = (r_state == ST_IDLE) && i_clr_req;
  assign w_pop   = (r_state == ST_IDLE) && !i_clr_req && (w_count != 3'd0);
  assign w_head  = bp_entry_t'(w_headBits);

  assign w_unusedAddrBits = ^{i_rob_bp_inst_addr0[XLEN-1:BP_SIZE_WIDTH],
                              i_rob_bp_inst_addr1[XLEN-1:BP_SIZE_WIDTH]};

  bp_update_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push0 (w_push0),
    .i_data0 (make_entry(i_rob_bp_inst_addr0, i_rob_bp_jump0, i_rob_bp_correct0)),
    .i_push1 (w_push1),
    .i_data1 (make_entry(i_rob_bp_inst_addr1, i_rob_bp_jump1, i_rob_bp_correct1)),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_headBits),
    .o_count (w_count)
  );

  // IDLE drains one queued update per cycle; CLEAR walks every table index, then returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_walkIdx   <= '0;
      r_wrEnable  <= 1'b0;
      r_wrIndex   <= '0;
      r_wrJump    <= 1'b0;
      r_wrCorrect <= 1'b0;
      r_wrClear   <= 1'b0;
      r_lastClear <= 1'b0;
      r_clrDone   <= 1'b0;
      r_overflow  <= 1'b0;
      r_updCnt    <= '0;
    end else begin
      r_wrEnable  <= 1'b0;
      r_wrClear   <= 1'b0;
      r_lastClear <= 1'b0;
      r_clrDone   <= r_lastClear;
      if (w_full && (i_rob_bp_enable0 || i_rob_bp_enable1)) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state   <= ST_CLEAR;
            r_walkIdx <= '0;
          end else if (w_pop) begin
            r_wrEnable  <= 1'b1;
            r_wrIndex   <= w_head.index;
            r_wrJump    <= w_head.jump;
            r_wrCorrect <= w_head.correct;
            r_updCnt    <= r_updCnt + 1'b1;
          end
        end
        ST_CLEAR: begin
          r_wrEnable  <= 1'b1;
          r_wrClear   <= 1'b1;
          r_wrIndex   <= r_walkIdx;
          r_wrJump    <= 1'b0;
          r_wrCorrect <= 1'b0;
          r_walkIdx   <= r_walkIdx + 1'b1;
          if (r_walkIdx == LAST_IDX) begin
            r_state     <= ST_IDLE;
            r_lastClear <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bpu_full      = w_full;
  assign o_bp_wr_enable  = r_wrEnable;
  assign o_bp_wr_index   = r_wrIndex;
  assign o_bp_wr_jump    = r_wrJump;
  assign o_bp_wr_correct = r_wrCorrect;
  assign o_bp_wr_clear   = r_wrClear;
  assign o_clr_done      = r_clrDone;
  assign o_bpu_overflow  = r_overflow;
  assign o_upd_cnt       = r_updCnt;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed and queue-model checks of the predictor update controller.
module tb_bp_update_ctrl;
  import bp_update_ctrl_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     en0, j0, c0, en1, j1, c1, clrReq;
  logic [XLEN-1:0]          addr0, addr1;
  logic                     full, wrEn, wrJump, wrCorrect, wrClear, clrDone, overflow;
  logic [BP_SIZE_WIDTH-1:0] wrIndex;
  logic [XLEN-1:0]          updCnt;

  int nVectors;
  int nMiscompares;

  bp_update_ctrl dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_rob_bp_enable0    (en0),
    .i_rob_bp_inst_addr0 (addr0),
    .i_rob_bp_jump0      (j0),
    .i_rob_bp_correct0   (c0),
    .i_rob_bp_enable1    (en1),
    .i_rob_bp_inst_addr1 (addr1),
    .i_rob_bp_jump1      (j1),
    .i_rob_bp_correct1   (c1),
    .i_clr_req           (clrReq),
    .o_bpu_full          (full),
    .o_bp_wr_enable      (wrEn),
    .o_bp_wr_index       (wrIndex),
    .o_bp_wr_jump        (wrJump),
    .o_bp_wr_correct     (wrCorrect),
    .o_bp_wr_clear       (wrClear),
    .o_clr_done          (clrDone),
    .o_bpu_overflow      (overflow),
    .o_upd_cnt           (updCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e0, input logic [XLEN-1:0] a0, input logic jj0, input logic cc0,
                       input logic e1, input logic [XLEN-1:0] a1, input logic jj1, input logic cc1);
    en0 = e0; addr0 = a0; j0 = jj0; c0 = cc0;
    en1 = e1; addr1 = a1; j1 = jj1; c1 = cc1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    clrReq = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    clrReq = 1'b0;
    #3;
    got = {full, wrEn, wrIndex, wrJump, wrCorrect, wrClear, clrDone, overflow};
    nVectors++;
    if (got !== 11'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", got, 11'd0);
    end
    nVectors++;
    if (updCnt !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_updcnt got=%0d want=0", updCnt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1, 32'h104, 1, 1, 0, '0, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    nVectors++;
    if (wrEn !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL single_latency got=%b want=0", wrEn);
    end
    tick();
    nVectors++;
    if ({wrEn, wrIndex, wrJump, wrCorrect, wrClear} !== {1'b1, 4'h4, 1'b1, 1'b1, 1'b0}) begin
      nMiscompares++;
      $display("[TB] FAIL single_write got=%b_%h_%b%b%b want=1_4_110",
               wrEn, wrIndex, wrJump, wrCorrect, wrClear);
    end
    nVectors++;
    if (updCnt !== 32'd1) begin
      nMiscompares++;
      $display("[TB] FAIL single_updcnt got=%0d want=1", updCnt);
    end
    tick();
    nVectors++;
    if (wrEn !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL single_oneshot got=%b want=0", wrEn);
    end
  endtask

  task automatic test_dual_full();
    logic [5:0] expW [4];
    logic       expFull [4];
    expW[0] = {4'h0, 1'b0, 1'b1};
    expW[1] = {4'h1, 1'b1, 1'b0};
    expW[2] = {4'h2, 1'b1, 1'b1};
    expW[3] = {4'h3, 1'b0, 1'b0};
    expFull[0] = 1'b1; expFull[1] = 1'b0; expFull[2] = 1'b0; expFull[3] = 1'b0;
    drive(1, 32'h10, 0, 1, 1, 32'h21, 1, 0);
    tick();
    nVectors++;
    if (full !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL dual_full_after1 got=%b want=0", full);
    end
    drive(1, 32'h32, 1, 1, 1, 32'h43, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      nVectors++;
      if ({wrEn, wrIndex, wrJump, wrCorrect} !== {1'b1, expW[k]}) begin
        nMiscompares++;
        $display("[TB] FAIL dual_write%0d got=%b_%h_%b%b want=1_%h_%b%b", k,
                 wrEn, wrIndex, wrJump, wrCorrect, expW[k][5:2], expW[k][1], expW[k][0]);
      end
      nVectors++;
      if (full !== expFull[k]) begin
        nMiscompares++;
        $display("[TB] FAIL dual_full%0d got=%b want=%b", k, full, expFull[k]);
      end
      tick();
    end
    nVectors++;
    if (wrEn !== 1'b0 || updCnt !== 32'd5) begin
      nMiscompares++;
      $display("[TB] FAIL dual_drained got=en%b cnt%0d want=en0 cnt5", wrEn, updCnt);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] expIdx [3];
    expIdx[0] = 4'h7; expIdx[1] = 4'h8; expIdx[2] = 4'h9;
    drive(1, 32'h06, 0, 0, 1, 32'h07, 0, 0);
    tick();
    drive(1, 32'h08, 0, 0, 1, 32'h09, 0, 0);
    tick();
    nVectors++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL ovf_prefull got=full%b ovf%b want=full1 ovf0", full, overflow);
    end
    drive(1, 32'h5E, 1, 1, 0, '0, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    nVectors++;
    if (overflow !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL ovf_flag got=%b want=1", overflow);
    end
    for (int k = 0; k < 3; k++) begin
      nVectors++;
      if (wrEn !== 1'b1 || wrIndex !== expIdx[k]) begin
        nMiscompares++;
        $display("[TB] FAIL ovf_write%0d got=en%b idx%h want=en1 idx%h", k, wrEn, wrIndex, expIdx[k]);
      end
      tick();
    end
    nVectors++;
    if (wrEn !== 1'b0 || overflow !== 1'b1 || updCnt !== 32'd9) begin
      nMiscompares++;
      $display("[TB] FAIL ovf_dropped got=en%b ovf%b cnt%0d want=en0 ovf1 cnt9", wrEn, overflow, updCnt);
    end
  endtask

  task automatic test_clear();
    drive(1, 32'hA1, 1, 0, 1, 32'hB2, 0, 1);
    tick();
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    nVectors++;
    if (wrEn !== 1'b0 || full !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL clr_enter got=en%b full%b want=en0 full1", wrEn, full);
    end
    for (int k = 0; k < BP_SIZE; k++) begin
      clrReq = (k == 7);
      tick();
      clrReq = 1'b0;
      nVectors++;
      if ({wrEn, wrClear, wrJump, wrCorrect} !== 4'b1100 || wrIndex !== BP_SIZE_WIDTH'(k) || clrDone !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL clr_walk%0d got=en%b clr%b j%b c%b idx%0d done%b want=en1 clr1 j0 c0 idx%0d done0",
                 k, wrEn, wrClear, wrJump, wrCorrect, wrIndex, clrDone, k);
      end
    end
    nVectors++;
    if (full !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL clr_exit_full got=%b want=0", full);
    end
    tick();
    nVectors++;
    if (clrDone !== 1'b1 || wrEn !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL clr_done got=done%b en%b want=done1 en0", clrDone, wrEn);
    end
    tick();
    nVectors++;
    if (clrDone !== 1'b0 || wrEn !== 1'b0 || updCnt !== 32'd9) begin
      nMiscompares++;
      $display("[TB] FAIL clr_after got=done%b en%b cnt%0d want=done0 en0 cnt9", clrDone, wrEn, updCnt);
    end
  endtask

  task automatic test_reset_midclear();
    logic [10:0] got;
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    nVectors++;
    if (wrIndex !== 4'd5 || wrClear !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL rstclr_pos got=idx%0d clr%b want=idx5 clr1", wrIndex, wrClear);
    end
    rst_n = 1'b0;
    #2;
    got = {full, wrEn, wrIndex, wrJump, wrCorrect, wrClear, clrDone, overflow};
    nVectors++;
    if (got !== 11'd0 || updCnt !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL rstclr_async got=%b cnt%0d want=%b cnt0", got, updCnt, 11'd0);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      nVectors++;
      if (clrDone !== 1'b0 || wrEn !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL rstclr_quiet%0d got=done%b en%b want=done0 en0", k, clrDone, wrEn);
      end
    end
    drive(1, 32'h3A7, 0, 1, 0, '0, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    tick();
    nVectors++;
    if ({wrEn, wrIndex, wrJump, wrCorrect, wrClear} !== {1'b1, 4'h7, 1'b0, 1'b1, 1'b0} || updCnt !== 32'd1) begin
      nMiscompares++;
      $display("[TB] FAIL rstclr_update got=%b_%h_%b%b%b cnt%0d want=1_7_010 cnt1",
               wrEn, wrIndex, wrJump, wrCorrect, wrClear, updCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]      q[$];
    logic [5:0]      want;
    logic [5:0]      e0, e1;
    logic            p0, p1;
    logic [XLEN-1:0] a0, a1;
    int              pendingBefore;
    int              accepted;
    accepted = 0;
    applyReset();
    for (int cyc = 0; cyc < 3006; cyc++) begin
      p0 = 1'b0;
      p1 = 1'b0;
      if (cyc < 3000 && !full) begin
        p0 = 1'($urandom_range(0, 1));
        p1 = 1'($urandom_range(0, 1));
      end
      a0 = $urandom;
      a1 = $urandom;
      e0 = {a0[3:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      e1 = {a1[3:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      drive(p0, a0, e0[1], e0[0], p1, a1, e1[1], e1[0]);
      pendingBefore = q.size();
      tick();
      nVectors++;
      if (wrEn !== (pendingBefore > 0)) begin
        nMiscompares++;
        $display("[TB] FAIL rnd_enable cyc%0d got=%b want=%b", cyc, wrEn, pendingBefore > 0);
      end
      if (wrEn === 1'b1 && q.size() > 0) begin
        want = q.pop_front();
        nVectors++;
        if ({wrIndex, wrJump, wrCorrect} !== want || wrClear !== 1'b0) begin
          nMiscompares++;
          $display("[TB] FAIL rnd_data cyc%0d got=%h_%b%b clr%b want=%h_%b%b clr0", cyc,
                   wrIndex, wrJump, wrCorrect, wrClear, want[5:2], want[1], want[0]);
        end
      end
      if (p0) q.push_back(e0);
      if (p1) q.push_back(e1);
      accepted += int'(p0) + int'(p1);
      nVectors++;
      if (full !== (q.size() >= 3)) begin
        nMiscompares++;
        $display("[TB] FAIL rnd_full cyc%0d got=%b want=%b", cyc, full, q.size() >= 3);
      end
    end
    drive(0, '0, 0, 0, 0, '0, 0, 0);
    nVectors++;
    if (q.size() != 0 || updCnt !== 32'(accepted) || overflow !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL rnd_final got=left%0d cnt%0d ovf%b want=left0 cnt%0d ovf0",
               q.size(), updCnt, overflow, accepted);
    end
  endtask

  initial begin
    nVectors = 0;
    nMiscompares = 0;
    clrReq = 1'b0;
    test_reset();
    test_single();
    test_dual_full();
    test_overflow();
    test_clear();
    test_reset_midclear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
